// File: rtl/prefix_pkg.sv
// Shared helpers for the prefix add/sub pipeline: log2, stage count and
// parameter legality, evaluated at elaboration time.
package prefix_pkg;

   localparam int WIDTH_MIN = 4;
   localparam int WIDTH_MAX = 64;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // One input stage plus one register group per LPS prefix levels (last group may be short).
   function automatic int num_stages(input int width, input int lps);
      return 1 + (clog2(width) + lps - 1) / lps;
   endfunction

   function automatic bit params_ok(input int width, input int lps);
      return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
             ((width & (width - 1)) == 0) &&
             (lps >= 1) && (lps <= clog2(width));
   endfunction

endpackage

// File: rtl/prefix_addsub_pipe_if.sv
// Operation/result handshake bundle for prefix_addsub_pipe.
interface prefix_addsub_pipe_if #(
   parameter int WIDTH = 16,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic [TAG_W-1:0] tag_in;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   logic [TAG_W-1:0] tag_out;

   modport master (
      output in_valid, a, b, cin, sub, tag_in, flush, out_ready,
      input  in_ready, out_valid, s, cout, ovf, tag_out
   );

   modport slave (
      input  in_valid, a, b, cin, sub, tag_in, flush, out_ready,
      output in_ready, out_valid, s, cout, ovf, tag_out
   );
endinterface

// File: rtl/prefix_cell.sv
// Kogge-Stone (G,P) combine. The grey variant produces only the group
// generate; its P output is tied low because nothing downstream reads it.
module prefix_cell #(
   parameter bit GREY = 1'b0
) (
   input  logic gh,
   input  logic ph,
   input  logic gl,
   input  logic pl,
   output logic g,
   output logic p
);
   assign g = gh | (ph & gl);

   if (GREY) begin : g_grey
      assign p = 1'b0;
   end else begin : g_black
      assign p = ph & pl;
   end
endmodule

// File: rtl/prefix_addsub_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with whole-pipe stall, flush and
// an in-order sideband tag; a register closes every LPS prefix levels.
module prefix_addsub_pipe
   import prefix_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LPS   = 2,
   parameter int TAG_W = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   prefix_addsub_pipe_if.slave bus
);
   localparam int NLEV   = clog2(WIDTH);
   localparam int L      = num_stages(WIDTH, LPS);
   localparam int STAGES = L - 1;
   localparam int KL     = NLEV - 1;

   if (!params_ok(WIDTH, LPS)) begin : g_bad_params
      $error("prefix_addsub_pipe: illegal WIDTH=%0d LPS=%0d", WIDTH, LPS);
   end

   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      logic             ci;
      logic [TAG_W-1:0] tag;
   } s0_t;

   logic              adv;
   logic              acc;
   logic [STAGES:0]   vld_pipe;

   // The pipe moves as a unit: any slot may advance only if the output slot can.
   assign adv          = bus.out_ready | ~vld_pipe[STAGES];
   assign acc          = bus.in_valid & adv & ~bus.flush;
   assign bus.in_ready = adv;
   assign bus.out_valid = vld_pipe[STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         vld_pipe <= '0;
      else if (bus.flush) vld_pipe <= '0;
      else if (adv)       vld_pipe <= {vld_pipe[STAGES-1:0], acc};
   end

   // Stage 0: bitwise propagate/generate with b conditionally inverted.
   logic [WIDTH-1:0] b_eff;
   s0_t              s0_q;

   assign b_eff = bus.b ^ {WIDTH{bus.sub}};

   always_ff @(posedge clk) begin
      if (adv) begin
         s0_q.p   <= bus.a ^ b_eff;
         s0_q.g   <= bus.a & b_eff;
         s0_q.ci  <= bus.cin ^ bus.sub;
         s0_q.tag <= bus.tag_in;
      end
   end

   for (genvar k = 0; k < NLEV; k++) begin : g_lvl
      localparam int D = 1 << k;

      logic [WIDTH-1:0] gi, pi, poi, gn, pn;
      logic             cii;
      logic [TAG_W-1:0] tgi;

      if (k == 0) begin : g_first
         // Carry-in folds into bit 0 so every prefix G is a true carry out.
         assign gi  = {s0_q.g[WIDTH-1:1], s0_q.g[0] | (s0_q.p[0] & s0_q.ci)};
         assign pi  = s0_q.p;
         assign poi = s0_q.p;
         assign cii = s0_q.ci;
         assign tgi = s0_q.tag;
      end else begin : g_rest
         assign gi  = g_lvl[k-1].g_nxt.go;
         assign pi  = g_lvl[k-1].g_nxt.po;
         assign poi = g_lvl[k-1].g_nxt.poo;
         assign cii = g_lvl[k-1].g_nxt.cio;
         assign tgi = g_lvl[k-1].g_nxt.tgo;
      end

      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i >= D) begin : g_cell
            // Once a span reaches bit 0 its P is never consumed again.
            prefix_cell #(.GREY(i < 2 * D)) u_cell (
               .gh (gi[i]),
               .ph (pi[i]),
               .gl (gi[i-D]),
               .pl (pi[i-D]),
               .g  (gn[i]),
               .p  (pn[i])
            );
         end else begin : g_pass
            assign gn[i] = gi[i];
            assign pn[i] = pi[i];
         end
      end

      if (k < NLEV - 1) begin : g_nxt
         logic [WIDTH-1:0] go, po, poo;
         logic             cio;
         logic [TAG_W-1:0] tgo;

         if (((k + 1) % LPS) == 0) begin : g_reg
            always_ff @(posedge clk) begin
               if (adv) begin
                  go  <= gn;
                  po  <= pn;
                  poo <= poi;
                  cio <= cii;
                  tgo <= tgi;
               end
            end
         end else begin : g_wire
            assign go  = gn;
            assign po  = pn;
            assign poo = poi;
            assign cio = cii;
            assign tgo = tgi;
         end
      end
   end

   // Final register holds the architectural result.
   logic [WIDTH-1:0] s_d, s_q;
   logic             cout_d, ovf_d, cout_q, ovf_q;
   logic [TAG_W-1:0] tag_q;

   assign s_d    = g_lvl[KL].poi ^ {g_lvl[KL].gn[WIDTH-2:0], g_lvl[KL].cii};
   assign cout_d = g_lvl[KL].gn[WIDTH-1];
   assign ovf_d  = g_lvl[KL].gn[WIDTH-1] ^ g_lvl[KL].gn[WIDTH-2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         tag_q  <= '0;
      end else if (adv) begin
         s_q    <= s_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
         tag_q  <= g_lvl[KL].tgi;
      end
   end

   assign bus.s       = s_q;
   assign bus.cout    = cout_q;
   assign bus.ovf     = ovf_q;
   assign bus.tag_out = tag_q;

endmodule

// File: tb/tb_prefix_addsub_pipe.sv
// Directed bench for prefix_addsub_pipe (WIDTH=16, LPS=2) with an arithmetic
// reference model checked every cycle against the DUT outputs.
module tb_prefix_addsub_pipe;
   localparam int W   = 16;
   localparam int TW  = 4;
   localparam int LAT = 3;
   localparam int SMAX = 32767;
   localparam int SMIN = -32768;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prefix_addsub_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   prefix_addsub_pipe #(.WIDTH(W), .LPS(2), .TAG_W(TW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [W-1:0]  s;
      logic          cout;
      logic          ovf;
      logic [TW-1:0] tag;
   } res_t;

   int n_chk  = 0;
   int n_fail = 0;
   logic [TW-1:0] got_tags[$];
   res_t slot[LAT];
   bit   sv[LAT];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Plain integer arithmetic: unsigned range gives cout, signed range gives ovf.
   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub, input logic [TW-1:0] tag);
      res_t r;
      int ua, ub, sa, sb, ci, ur, sr;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      ci = cin ? 1 : 0;
      if (!sub) begin
         ur = ua + ub + ci;
         sr = sa + sb + ci;
         r.cout = (ur >= 65536);
      end else begin
         ur = ua - ub - ci;
         sr = sa - sb - ci;
         r.cout = (ur >= 0);
      end
      r.s   = ur[W-1:0];
      r.ovf = (sr > SMAX) || (sr < SMIN);
      r.tag = tag;
      return r;
   endfunction

   // Observable behaviour: fixed latency LAT, whole pipe holds while output is blocked.
   always @(negedge clk) begin
      bit exp_ov, adv;
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) sv[i] = 1'b0;
      end else begin
         exp_ov = sv[LAT-1];
         adv    = bus.out_ready || !exp_ov;
         check("out_valid", bus.out_valid, exp_ov);
         check("in_ready", bus.in_ready, adv);
         if (exp_ov && bus.out_valid)
            check("result", {bus.s, bus.cout, bus.ovf, bus.tag_out},
                  {slot[LAT-1].s, slot[LAT-1].cout, slot[LAT-1].ovf, slot[LAT-1].tag});
         if (exp_ov && bus.out_ready) got_tags.push_back(slot[LAT-1].tag);
         if (bus.flush) begin
            for (int i = 0; i < LAT; i++) sv[i] = 1'b0;
         end else if (adv) begin
            for (int i = LAT - 1; i > 0; i--) begin
               sv[i]   = sv[i-1];
               slot[i] = slot[i-1];
            end
            sv[0]   = bus.in_valid;
            slot[0] = model(bus.a, bus.b, bus.cin, bus.sub, bus.tag_in);
         end
      end
   end

   task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input logic [TW-1:0] tag);
      bus.in_valid = v;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      bus.tag_in   = tag;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub,
                         input logic [W-1:0] es, input logic ec, input logic eo);
      int n;
      bus.out_ready = 1'b1;
      drive(1'b1, a, b, cin, sub, 4'hA);
      cyc();
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 12) begin
         cyc();
         n++;
      end
      check({name, "_latency"}, n, LAT);
      check({name, "_s"}, bus.s, es);
      check({name, "_cout"}, bus.cout, ec);
      check({name, "_ovf"}, bus.ovf, eo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, c;
      bit acc;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_s", bus.s, 0);
      check("rst_cout", bus.cout, 0);
      check("rst_ovf", bus.ovf, 0);
      check("rst_tag", bus.tag_out, 0);
      check("rst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      check("post_rst_in_ready", bus.in_ready, 1);
      cyc();

      run_op("add0", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
      run_op("add1", 16'h0069, 16'h0069, 1'b0, 1'b0, 16'h00D2, 1'b0, 1'b0);
      run_op("add2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add3", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_op("add4", 16'h55AA, 16'hAA55, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add5", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_op("sub0", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      run_op("sub1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_op("sub2", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
      run_op("sub3", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      repeat (3) cyc();

      // Back-to-back tags 0..7 with the consumer stalled for cycles 4-6.
      got_tags.delete();
      idx = 0;
      c = 0;
      while (idx < 8 && c < 40) begin
         bus.out_ready = !(c >= 4 && c <= 6);
         drive(1'b1, 16'(idx * 16'h1111), 16'(idx * 16'h0F0F), idx[1], idx[0], idx[TW-1:0]);
         @(negedge clk);
         acc = bus.in_ready;
         if (c >= 4 && c <= 6) check("stall_in_ready", bus.in_ready, 0);
         cyc();
         if (acc) idx++;
         c++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (6) cyc();
      check("stall_count", got_tags.size(), 8);
      for (int i = 0; i < 8 && i < got_tags.size(); i++)
         check("stall_order", got_tags[i], i);

      // Two ops in flight, third presented together with flush.
      drive(1'b1, 16'h1000, 16'h0234, 1'b0, 1'b0, 4'h8);
      cyc();
      drive(1'b1, 16'h2000, 16'h0345, 1'b0, 1'b1, 4'h9);
      cyc();
      drive(1'b1, 16'h3000, 16'h0456, 1'b1, 1'b0, 4'hA);
      bus.flush = 1'b1;
      cyc();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("flush_no_out", bus.out_valid, 0);
         cyc();
      end
      run_op("post_flush", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      repeat (3) cyc();

      // Asynchronous reset with results in flight and the output stalled.
      bus.out_ready = 1'b0;
      drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 4'hB);
      cyc();
      drive(1'b1, 16'h4321, 16'h0101, 1'b0, 1'b0, 4'hC);
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      check("pre_rst_valid", bus.out_valid, 1);
      check("pre_rst_s", bus.s, 16'h2345);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_valid", bus.out_valid, 0);
      check("async_rst_s", bus.s, 0);
      check("async_rst_tag", bus.tag_out, 0);
      check("async_rst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("no_stale", bus.out_valid, 0);
      end

      // Random traffic, back-pressure and occasional flush against the model.
      for (int i = 0; i < 400; i++) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 40) == 0);
         drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         cyc();
      end
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (8) cyc();
      check("drained", bus.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
